seg7_scan_driver: RTL and testbench

- Multiplexed N-digit 7-segment display driver for the fan-controller display path.
- Latches a packed hex/BCD value through a load strobe and scans the digits one at a time with a programmable on-time and a dead-time gap to suppress ghosting.
- Applies optional leading-zero blanking and drives the shared segment bus plus one-hot digit enables.
- Sits between the controller's value register and the top-level output pins.

---
 rtl/seg7_pkg.sv | 52 +++++
 rtl/seg7_scan_driver_if.sv | 43 ++++
 rtl/seg7_scan_driver_decoder.sv | 17 +
 rtl/seg7_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared segment bit indices, scan FSM state type and the
//               hex-to-7-segment glyph function for the scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Bit position of each segment on the shared segment bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Scan state machine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Glyph for a hex nibble, bit6 (g) down to bit0 (a), 1 = lit
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = 7'b0000000;
        case (nib)
            4'h0: g = 7'b0111111;
            4'h1: g = 7'b0000110;
            4'h2: g = 7'b1011011;
            4'h3: g = 7'b1001111;
            4'h4: g = 7'b1100110;
            4'h5: g = 7'b1101101;
            4'h6: g = 7'b1111101;
            4'h7: g = 7'b0000111;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1101111;
            4'hA: g = 7'b1110111;
            4'hB: g = 7'b1111100;
            4'hC: g = 7'b0111001;
            4'hD: g = 7'b1011110;
            4'hE: g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Value/control inputs and display outputs of the 7-segment
//               scan driver. Optional macro SEG7_SCAN_PWM_EN adds bright_i.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic [4*DIGITS-1:0]   value_i;
    logic                  load_i;
    logic                  blank_lz_i;
`ifdef SEG7_SCAN_PWM_EN
    logic [3:0]            bright_i;
`endif
    logic [6:0]            segments;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_o;

`ifdef SEG7_SCAN_PWM_EN
    modport master (
        output en, value_i, load_i, blank_lz_i, bright_i,
        input  segments, digit_en, frame_o
    );
    modport slave (
        input  en, value_i, load_i, blank_lz_i, bright_i,
        output segments, digit_en, frame_o
    );
`else
    modport master (
        output en, value_i, load_i, blank_lz_i,
        input  segments, digit_en, frame_o
    );
    modport slave (
        input  en, value_i, load_i, blank_lz_i,
        output segments, digit_en, frame_o
    );
`endif

endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_decoder
// Description : Combinational hex nibble to 7-segment glyph decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = seg7_glyph(nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed N-digit 7-segment scan driver with per-digit
//               on-time, dead-time gap, frame-coherent value latching and
//               leading-zero blanking. Optional macro SEG7_SCAN_PWM_EN adds
//               segment brightness gating via bright_i.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 1024,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
    localparam int c_VAL_W   = 4 * DIGITS;

    localparam logic [c_CNT_W-1:0] c_DRIVE_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_IDX_W-1:0]   w_idx_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_VAL_W-1:0]   r_shadow;
    logic [c_VAL_W-1:0]   r_frame;
    logic [c_VAL_W-1:0]   w_frame_nxt;
    logic                 w_frame_start;

    logic [c_VAL_W-1:0]   w_shifted;
    logic [3:0]           w_nibble;
    logic [6:0]           w_glyph;
    logic                 w_blank;

    logic [6:0]           r_segments;
    logic [DIGITS-1:0]    r_digit_en;
    logic                 r_frame_o;
    logic [6:0]           w_seg_nxt;
    logic [DIGITS-1:0]    w_de_nxt;

    // Next state, slot counter, digit index and frame value
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_frame_start = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt   = DRIVE;
                    w_idx_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_frame_start = 1'b1;
                end
                DRIVE: begin
                    if (r_cnt == c_DRIVE_LAST) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt = DRIVE;
                        w_cnt_nxt   = '0;
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt     = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        // A load landing on the frame-start edge is shown immediately
        w_frame_nxt = r_frame;
        if (w_frame_start) begin
            w_frame_nxt = bus.load_i ? bus.value_i : r_shadow;
        end
    end

    // Upper nibbles from the selected digit upwards; all-zero means leading zero
    assign w_shifted = w_frame_nxt >> {w_idx_nxt, 2'b00};
    assign w_nibble  = w_shifted[3:0];
    assign w_blank   = bus.blank_lz_i && (w_idx_nxt != '0) && (w_shifted == '0);

    seg7_scan_driver_decoder u_decoder (
        .nibble (w_nibble),
        .glyph  (w_glyph)
    );

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        w_seg_nxt = '0;
        w_de_nxt  = '0;
        if (w_state_nxt == DRIVE) begin
            w_de_nxt[w_idx_nxt] = 1'b1;
            if (!w_blank) begin
                w_seg_nxt = w_glyph;
            end
`ifdef SEG7_SCAN_PWM_EN
            if (w_cnt_nxt[3:0] > bus.bright_i) begin
                w_seg_nxt = '0;
            end
`endif
        end
    end

    // State, counters, value registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_frame    <= '0;
            r_segments <= '0;
            r_digit_en <= '0;
            r_frame_o  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_frame    <= w_frame_nxt;
            if (bus.load_i) begin
                r_shadow <= bus.value_i;
            end
            r_segments <= w_seg_nxt;
            r_digit_en <= w_de_nxt;
            r_frame_o  <= w_frame_start;
        end
    end

    assign bus.segments = r_segments;
    assign bus.digit_en = r_digit_en;
    assign bus.frame_o  = r_frame_o;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (DIGITS=2,
//               REFRESH_DIV=16, GAP_CYCLES=1). Honours SEG7_SCAN_PWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIGITS = 2;
    localparam int RD     = 16;
    localparam int GAPC   = 1;
    localparam int SLOT   = RD + GAPC;
    localparam int PERIOD = DIGITS * SLOT;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RD),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs written straight from the digit table (g..a)
    logic [6:0] glyph_ref [16];

    // Behavioural model: position within the frame, latched frame value
    bit         m_active;
    int         m_t;
    logic [7:0] m_shadow;
    logic [7:0] m_frame;
    logic [6:0] exp_seg;
    logic [1:0] exp_de;
    logic       exp_fo;

    typedef struct {
        int         n;
        bit         en;
        bit         load;
        logic [7:0] val;
        bit         blank;
        logic [6:0] seg;
        logic [1:0] de;
        bit         fo;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_shadow = '0;
        m_frame  = '0;
        exp_seg  = '0;
        exp_de   = '0;
        exp_fo   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_edge();
        int         d;
        int         w;
        logic [7:0] up;
        if (!bus.en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_t      = 0;
            end else begin
                m_t = (m_t + 1) % PERIOD;
            end
            if (m_t == 0) m_frame = bus.load_i ? bus.value_i : m_shadow;
        end
        if (bus.load_i) m_shadow = bus.value_i;
        exp_seg = '0;
        exp_de  = '0;
        exp_fo  = 1'b0;
        if (m_active) begin
            d = m_t / SLOT;
            w = m_t % SLOT;
            if (w < RD) begin
                exp_de = 2'(1 << d);
                exp_fo = (m_t == 0);
                up     = m_frame >> (4 * d);
                if (!(bus.blank_lz_i && d > 0 && up == 8'h00)) exp_seg = glyph_ref[up[3:0]];
`ifdef SEG7_SCAN_PWM_EN
                if ((w % 16) > int'(bus.bright_i)) exp_seg = '0;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_segments", 32'(bus.segments), 32'(exp_seg));
        check("model_digit_en", 32'(bus.digit_en), 32'(exp_de));
        check("model_frame_o",  32'(bus.frame_o),  32'(exp_fo));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        glyph_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        //           n   en load val    blk seg    de     fo
        tbl[0]  = '{ 1,  1, 0, 8'h00, 0, 7'h3F, 2'b01, 1};
        tbl[1]  = '{15,  1, 0, 8'h00, 0, 7'h3F, 2'b01, 0};
        tbl[2]  = '{ 1,  1, 0, 8'h00, 0, 7'h00, 2'b00, 0};
        tbl[3]  = '{ 1,  1, 0, 8'h00, 0, 7'h3F, 2'b10, 0};
        tbl[4]  = '{16,  1, 0, 8'h00, 0, 7'h00, 2'b00, 0};
        tbl[5]  = '{ 1,  1, 0, 8'h00, 0, 7'h3F, 2'b01, 1};
        tbl[6]  = '{ 5,  1, 1, 8'h3A, 0, 7'h3F, 2'b01, 0};
        tbl[7]  = '{12,  1, 0, 8'h3A, 0, 7'h3F, 2'b10, 0};
        tbl[8]  = '{17,  1, 0, 8'h3A, 0, 7'h77, 2'b01, 1};
        tbl[9]  = '{17,  1, 0, 8'h3A, 0, 7'h4F, 2'b10, 0};
        tbl[10] = '{17,  1, 1, 8'h05, 1, 7'h6D, 2'b01, 1};
        tbl[11] = '{17,  1, 0, 8'h05, 1, 7'h00, 2'b10, 0};
        tbl[12] = '{ 1,  1, 0, 8'h05, 0, 7'h3F, 2'b10, 0};
        tbl[13] = '{16,  1, 1, 8'h00, 1, 7'h3F, 2'b01, 1};
        tbl[14] = '{17,  1, 0, 8'h00, 1, 7'h00, 2'b10, 0};
        tbl[15] = '{16,  1, 0, 8'h00, 0, 7'h00, 2'b00, 0};
        tbl[16] = '{ 1,  1, 1, 8'hF1, 0, 7'h06, 2'b01, 1};
        tbl[17] = '{17,  1, 0, 8'hF1, 0, 7'h71, 2'b10, 0};

        // Reset held with the scan already enabled
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.load_i     = 1'b0;
        bus.value_i    = '0;
        bus.blank_lz_i = 1'b0;
`ifdef SEG7_SCAN_PWM_EN
        bus.bright_i   = 4'd15;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_segments", 32'(bus.segments), 32'h0);
        check("reset_digit_en", 32'(bus.digit_en), 32'h0);
        check("reset_frame_o",  32'(bus.frame_o),  32'h0);
        rst_n = 1'b1;

        // Directed vectors: scan timing, mid-frame load, blanking, bypass
        for (int i = 0; i < 18; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                bus.en         = tbl[i].en;
                bus.value_i    = tbl[i].val;
                bus.blank_lz_i = tbl[i].blank;
                bus.load_i     = tbl[i].load && (k == tbl[i].n - 1);
                tick();
            end
            bus.load_i = 1'b0;
            check($sformatf("tbl%0d_segments", i), 32'(bus.segments), 32'(tbl[i].seg));
            check($sformatf("tbl%0d_digit_en", i), 32'(bus.digit_en), 32'(tbl[i].de));
            check($sformatf("tbl%0d_frame_o",  i), 32'(bus.frame_o),  32'(tbl[i].fo));
        end

        // Enable dropped during the gap, then re-enabled
        repeat (16) tick();
        bus.en = 1'b0;
        tick();
        check("en_drop_segments", 32'(bus.segments), 32'h0);
        check("en_drop_digit_en", 32'(bus.digit_en), 32'h0);
        check("en_drop_frame_o",  32'(bus.frame_o),  32'h0);
        repeat (3) tick();
        check("idle_digit_en", 32'(bus.digit_en), 32'h0);
        bus.en = 1'b1;
        tick();
        check("reenable_digit_en", 32'(bus.digit_en), 32'h1);
        check("reenable_frame_o",  32'(bus.frame_o),  32'h1);
        check("reenable_segments", 32'(bus.segments), 32'h06);

        // Asynchronous reset in the middle of a drive slot
        repeat (5) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_segments", 32'(bus.segments), 32'h0);
        check("async_rst_digit_en", 32'(bus.digit_en), 32'h0);
        check("async_rst_frame_o",  32'(bus.frame_o),  32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_digit_en", 32'(bus.digit_en), 32'h1);
        check("post_rst_frame_o",  32'(bus.frame_o),  32'h1);
        check("post_rst_segments", 32'(bus.segments), 32'h3F);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.en     = ($urandom_range(0, 199) != 0);
            bus.load_i = ($urandom_range(0, 29) == 0);
            bus.value_i = 8'($urandom);
            if ($urandom_range(0, 49) == 0) bus.blank_lz_i = ~bus.blank_lz_i;
`ifdef SEG7_SCAN_PWM_EN
            if ($urandom_range(0, 99) == 0) bus.bright_i = 4'($urandom);
`endif
            tick();
        end
        bus.load_i     = 1'b0;
        bus.blank_lz_i = 1'b0;

`ifdef SEG7_SCAN_PWM_EN
        // Brightness 3: lit for the first four cycles of each 16-cycle slot
        bus.en       = 1'b0;
        bus.load_i   = 1'b1;
        bus.value_i  = 8'h88;
        bus.bright_i = 4'd3;
        tick();
        bus.load_i = 1'b0;
        bus.en     = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("pwm_c%0d_digit_en", k), 32'(bus.digit_en), 32'h1);
            check($sformatf("pwm_c%0d_segments", k), 32'(bus.segments), (k <= 3) ? 32'h7F : 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
